// File: rtl/ported_memory.sv
// Purpose: single-ported word memory shared by several requesters through a round-robin arbiter.
// Latency: ack is combinational in the request cycle; read data and valid arrive one cycle after ack.
// Backpressure: a requester without ack must hold req and its qualifiers; dropping req cancels the access cleanly.
module ported_memory #(
    parameter int data_width    = 16,
    parameter int address_width = 10,
    parameter int mem_depth     = 1 << address_width,
    parameter int ports         = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [ports-1:0]                 req,
    input  logic [ports-1:0]                 write_enable,
    input  logic [ports*address_width-1:0]   address,
    input  logic [ports*data_width-1:0]      data_in,
    output logic [ports-1:0]                 ack,
    output logic [ports*data_width-1:0]      data_out,
    output logic [ports-1:0]                 valid
);

    // Port index width; a single-port build still needs a one-bit index.
    localparam int gw = (ports > 1) ? $clog2(ports) : 1;

    logic [data_width-1:0]    mem [mem_depth];
    logic [gw-1:0]            last_grant;
    logic [gw-1:0]            cand;
    logic [gw-1:0]            grant_idx;
    logic                     grant_vld;
    logic [address_width-1:0] grant_addr;
    logic [data_width-1:0]    grant_din;
    logic                     grant_we;
    logic                     in_range;

    // Round-robin search starting just after the last granted port; reset suppresses all grants.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant;
        cand      = last_grant;
        ack       = '0;
        for (int k = 1; k <= ports; k++) begin
            cand = gw'((int'(last_grant) + k) % ports);
            if (!reset && !grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_vld) begin
            ack[grant_idx] = 1'b1;
        end
    end

    // Steer the winning port's qualifiers onto the single memory access path.
    always_comb begin
        grant_addr = address[grant_idx*address_width +: address_width];
        grant_din  = data_in[grant_idx*data_width +: data_width];
        grant_we   = write_enable[grant_idx];
        in_range   = (32'(grant_addr) < 32'(mem_depth));
    end

    // Storage is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (grant_vld && grant_we && in_range) begin
            mem[grant_addr] <= grant_din;
        end
    end

    // Arbiter history and per-port read result registers; valid is a one-cycle pulse per read grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= gw'(ports - 1);
            data_out   <= '0;
            valid      <= '0;
        end else begin
            valid <= '0;
            if (grant_vld) begin
                last_grant <= grant_idx;
                if (!grant_we) begin
                    valid[grant_idx] <= 1'b1;
                    data_out[grant_idx*data_width +: data_width] <= in_range ? mem[grant_addr] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ported_memory.sv
// Purpose: randomized and directed bench for ported_memory against a behavioural reference model.
// Latency: checks ack mid-cycle and read results just after the following clock edge.
// Backpressure: stimulus may drop req before ack, which the model treats as a cancelled request.
module tb_ported_memory;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1000;
    localparam int NP = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NP-1:0]     req;
    logic [NP-1:0]     write_enable;
    logic [NP*AW-1:0]  address;
    logic [NP*DW-1:0]  data_in;
    logic [NP-1:0]     ack;
    logic [NP*DW-1:0]  data_out;
    logic [NP-1:0]     valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_mem   [1 << AW];
    bit            m_known [1 << AW];
    logic [DW-1:0] m_dout  [NP];
    bit            m_dknown[NP];
    logic [NP-1:0] m_valid;
    int            m_last;

    ported_memory #(
        .data_width(DW), .address_width(AW), .mem_depth(DEPTH), .ports(NP)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .write_enable(write_enable),
        .address(address), .data_in(data_in), .ack(ack), .data_out(data_out), .valid(valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_grant(input logic [NP-1:0] r);
        for (int k = 1; k <= NP; k++) begin
            if (r[(m_last + k) % NP]) return (m_last + k) % NP;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = NP - 1;
        m_valid = '0;
        for (int i = 0; i < NP; i++) begin
            m_dout[i] = '0;
            m_dknown[i] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("valid", valid, m_valid);
        for (int i = 0; i < NP; i++) begin
            if (m_dknown[i]) chk($sformatf("data_out%0d", i), data_out[i*DW +: DW], m_dout[i]);
        end
    endtask

    // One clock cycle with whatever req/write_enable/address/data_in are currently driven.
    task automatic cycle();
        int g;
        int a;
        logic [NP-1:0] eack;
        @(negedge clock);
        g = exp_grant(req);
        eack = '0;
        if (g >= 0) eack[g] = 1'b1;
        chk("ack", ack, eack);
        @(posedge clock);
        m_valid = '0;
        if (g >= 0) begin
            m_last = g;
            a = int'(address[g*AW +: AW]);
            if (write_enable[g]) begin
                if (a < DEPTH) begin
                    m_mem[a] = data_in[g*DW +: DW];
                    m_known[a] = 1'b1;
                end
            end else begin
                m_valid[g] = 1'b1;
                if (a >= DEPTH) begin
                    m_dout[g] = '0;
                    m_dknown[g] = 1'b1;
                end else begin
                    m_dout[g] = m_mem[a];
                    m_dknown[g] = m_known[a];
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = r;
        write_enable = we;
        for (int i = 0; i < NP; i++) begin
            address[i*AW +: AW] = a;
            data_in[i*DW +: DW] = d;
        end
    endtask

    initial begin
        logic [DW-1:0] keep0;
        for (int i = 0; i < (1 << AW); i++) m_known[i] = 1'b0;
        reset = 1'b1;
        drive('1, '0, '0, '0);
        model_reset();
        #2;
        chk("reset_ack", ack, '0);
        @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b0;

        // Port 0 writes 0x1234 to address 5, port 1 reads it back the next cycle.
        drive(4'b0001, 4'b0001, 10'd5, 16'h1234);
        cycle();
        drive(4'b0010, 4'b0000, 10'd5, 16'h0);
        cycle();
        chk("raw_data1", data_out[DW +: DW], 16'h1234);
        chk("raw_valid1", valid, 4'b0010);
        drive(4'b0000, 4'b0000, 10'd0, 16'h0);
        cycle();

        // Preload 0xA0..0xA3 then port 1 alone streams reads of addresses 0..3.
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001, 4'b0001, AW'(i), DW'(16'hA0 + i));
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'b0010, 4'b0000, AW'(i), 16'h0);
            cycle();
            chk("stream_data", data_out[DW +: DW], DW'(16'hA0 + i));
        end

        // Two ports contend with reads: strict alternation.
        for (int i = 0; i < 6; i++) begin
            drive(4'b0011, 4'b0000, AW'(i % 4), 16'h0);
            cycle();
        end

        // Grant port 3, then req=1010 goes to port 1 then port 3; port 0 data untouched.
        keep0 = data_out[0 +: DW];
        drive(4'b1000, 4'b0000, 10'd2, 16'h0);
        cycle();
        drive(4'b1010, 4'b0000, 10'd3, 16'h0);
        cycle();
        chk("rr_port1", valid, 4'b0010);
        cycle();
        chk("rr_port3", valid, 4'b1000);
        chk("keep_dout0", data_out[0 +: DW], keep0);

        // Out-of-range address: write dropped, read gives zero; address 1 untouched.
        drive(4'b0001, 4'b0001, 10'd1, 16'h5A5A);
        cycle();
        drive(4'b0001, 4'b0001, 10'd1001, 16'hFFFF);
        cycle();
        drive(4'b0100, 4'b0000, 10'd1001, 16'h0);
        cycle();
        chk("oor_read", data_out[2*DW +: DW], 16'h0000);
        drive(4'b0100, 4'b0000, 10'd1, 16'h0);
        cycle();
        chk("oor_alias", data_out[2*DW +: DW], 16'h5A5A);

        // All ports requesting: each served once every four cycles.
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 4'b0000, AW'(i % 4), 16'h0);
            cycle();
        end

        // Read granted, then reset pulsed before the edge: read dropped, port 0 first afterwards.
        drive(4'b0100, 4'b0000, 10'd0, 16'h0);
        @(negedge clock);
        chk("pre_reset_ack", ack, 4'b0100);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_ack_forced", ack, '0);
        @(posedge clock);
        #1;
        model_reset();
        check_outputs();
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 10'd3, 16'h0);
        cycle();
        chk("post_reset_first", valid, 4'b0001);

        // Randomized traffic with per-port qualifiers and occasional out-of-range addresses.
        for (int n = 0; n < 400; n++) begin
            req = NP'($urandom);
            write_enable = NP'($urandom);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 9) == 0)
                    address[i*AW +: AW] = AW'($urandom_range(DEPTH, (1 << AW) - 1));
                else
                    address[i*AW +: AW] = AW'($urandom_range(0, 15));
                data_in[i*DW +: DW] = DW'($urandom);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
